pipeline_hazard_ctrl: RTL
=========================

Name: pipeline_hazard_ctrl

Overview:
- Central hazard and stall sequencer for the 5-stage pipeline.
- Drives write-enable (stall) and flush controls for PC, IF/ID, ID/EX, EX/MEM and MEM/WB.
- Sequences the I-cache and D-cache miss-fill handshakes on the single shared memory port.
- Resolves load-use hazards and branch mispredicts, and keeps stall and flush performance counters.

Parameters:
- CNT_W, 32, width of the saturating performance counters.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; one clock; reset is asynchronous and active-high.
- if_id_rs  in  5  rs field of the instruction in ID.
- if_id_rt  in  5  rt field of the instruction in ID.
- id_ex_rt  in  5  destination of the instruction in EX.
- id_ex_mem_read  in  1  the instruction in EX is a load.
- mispredict  in  1  MEM-stage branch resolved against the prediction.
- imiss  in  1  IF fetch valid and I-cache miss.
- dmiss  in  1  MEM access valid and D-cache miss.
- icache_fill_done  in  1  one-cycle pulse: I-fill complete.
- dcache_fill_done  in  1  one-cycle pulse: D-fill complete.
- icache_fill_req  out  1  I-cache fill request (level).
- dcache_fill_req  out  1  D-cache fill request (level).
- pc_write_en  out  1  PC update enable.
- if_id_write_en, id_ex_write_en, ex_mem_write_en, mem_wb_write_en  out  1 each  pipeline register enables.
- if_id_flush_en, id_ex_flush_en, ex_mem_flush_en, mem_wb_flush_en  out  1 each  pipeline register flushes.
- stall_cnt  out  CNT_W  cycles with pc_write_en=0.
- flush_cnt  out  CNT_W  mispredicts serviced.

Behaviour:
- Reset: rst high forces state RUN and zeroes both counters and both fill_req outputs.
- Reset: while rst is high, all write_en and flush_en outputs are 0.
- Reset mid-fill: the request is dropped immediately, and a fill_done arriving after reset is ignored.
- States: RUN, ISTALL, DSTALL, ISTALL_DFRZ.
- fill_req outputs are Moore outputs:
  - icache_fill_req=1 in ISTALL and ISTALL_DFRZ.
  - dcache_fill_req=1 in DSTALL only.
  - The two requests are never both high.
- Stage enables and flushes are combinational from state and inputs (same-cycle effect). Default: every write_en=1, every flush_en=0.
- Priority in RUN, highest first:
  1. dmiss: freeze PC, IF/ID, ID/EX and EX/MEM (write_en=0); mem_wb_flush_en=1; next state DSTALL.
  2. mispredict: pc_write_en=1 (redirect); if_id_flush_en, id_ex_flush_en and ex_mem_flush_en=1; flush_cnt+1; imiss and load-use ignored this cycle.
  3. imiss: pc_write_en=0; if_id_flush_en=1 (bubble into ID); later stages advance; next state ISTALL.
  4. load-use, i.e. id_ex_mem_read and id_ex_rt!=0 and (id_ex_rt==if_id_rs or id_ex_rt==if_id_rt): pc_write_en=0, if_id_write_en=0, id_ex_flush_en=1; single cycle, no state change.
- DSTALL:
  - Outputs as RUN case 1 every cycle.
  - On dcache_fill_done, go to RUN that cycle. Outputs in that cycle are still frozen.
  - mispredict and imiss are ignored; they remain visible because their stages are frozen.
- ISTALL:
  - Outputs as RUN case 3.
  - Load-use also applied: the ID/EX flush still occurs.
  - mispredict: apply the RUN case 2 flushes plus pc_write_en=1, stay in ISTALL; flush_cnt+1.
  - dmiss: outputs as RUN case 1 plus if_id_flush_en=0; next state ISTALL_DFRZ.
  - On icache_fill_done, go to RUN.
  - If dmiss and icache_fill_done occur together, go to DSTALL.
- ISTALL_DFRZ:
  - All stage write_en=0 except mem_wb_write_en=1; mem_wb_flush_en=1.
  - On icache_fill_done, go to DSTALL.
- fill_done pulses in a state that does not request that fill are ignored.
- Counters:
  - stall_cnt increments in every non-reset cycle in which pc_write_en=0.
  - flush_cnt increments in every serviced mispredict cycle.
  - Both saturate at all-ones and never wrap.
- Latency: hazard response in the same cycle; fill_req rises one cycle after the miss is first seen in RUN.

Test Plan:
- Load-use: id_ex_mem_read=1, id_ex_rt=5, if_id_rs=5 in RUN -> one cycle of pc_write_en=0, if_id_write_en=0, id_ex_flush_en=1; stall_cnt=1. Same with id_ex_rt=0 -> no stall.
- Mispredict with imiss and load-use asserted in RUN -> pc_write_en=1; if_id_flush_en, id_ex_flush_en, ex_mem_flush_en=1; state stays RUN; flush_cnt=1.
- dmiss held for 10 cycles, dcache_fill_done pulsed on cycle 10 -> dcache_fill_req high cycles 2..10; ex_mem_write_en=0 and mem_wb_flush_en=1 for all 10 cycles; RUN on cycle 11; stall_cnt=10.
- imiss then dmiss on ISTALL cycle 3, icache_fill_done on cycle 6 -> icache_fill_req stays high until done, then dcache_fill_req rises on cycle 7; dcache_fill_req never overlaps icache_fill_req.
- Reset asserted during DSTALL (async, mid-cycle) -> dcache_fill_req falls immediately, counters read 0; after release, state is RUN and default enables are 1.
- Saturation: preload stall_cnt near all-ones with CNT_W=4 and stall 20 cycles -> stall_cnt holds 15.

Source files
------------

// File: rtl/pipeline_hazard_ctrl_if.sv
// pipeline_hazard_ctrl_if: hazard inputs, fill handshakes, stage controls and counters
interface pipeline_hazard_ctrl_if #(parameter int CNT_W = 32);
  logic [4:0] if_id_rs, if_id_rt, id_ex_rt;
  logic id_ex_mem_read, mispredict, imiss, dmiss, icache_fill_done, dcache_fill_done;
  logic icache_fill_req, dcache_fill_req, pc_write_en;
  logic if_id_write_en, id_ex_write_en, ex_mem_write_en, mem_wb_write_en;
  logic if_id_flush_en, id_ex_flush_en, ex_mem_flush_en, mem_wb_flush_en;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
  modport master (
    input  if_id_rs, if_id_rt, id_ex_rt, id_ex_mem_read, mispredict, imiss, dmiss,
           icache_fill_done, dcache_fill_done,
    output icache_fill_req, dcache_fill_req, pc_write_en,
           if_id_write_en, id_ex_write_en, ex_mem_write_en, mem_wb_write_en,
           if_id_flush_en, id_ex_flush_en, ex_mem_flush_en, mem_wb_flush_en,
           stall_cnt, flush_cnt
  );
  modport slave (
    output if_id_rs, if_id_rt, id_ex_rt, id_ex_mem_read, mispredict, imiss, dmiss,
           icache_fill_done, dcache_fill_done,
    input  icache_fill_req, dcache_fill_req, pc_write_en,
           if_id_write_en, id_ex_write_en, ex_mem_write_en, mem_wb_write_en,
           if_id_flush_en, id_ex_flush_en, ex_mem_flush_en, mem_wb_flush_en,
           stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush sequencer with I/D miss-fill handshakes and perf counters
module pipeline_hazard_ctrl #(parameter int CNT_W = 32) (
  input logic clk,
  input logic rst,
  pipeline_hazard_ctrl_if.master bus
);
  typedef enum logic [1:0] {RUN, ISTALL, DSTALL, ISTALL_DFRZ} state_e;
  state_e state_q, state_d;
  logic icache_fill_req_q, icache_fill_req_d, dcache_fill_req_q, dcache_fill_req_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
  logic pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we;
  logic if_id_fl, id_ex_fl, ex_mem_fl, mem_wb_fl, mp_srv, load_use;
  assign load_use = bus.id_ex_mem_read && bus.id_ex_rt != 5'd0 &&
                    (bus.id_ex_rt == bus.if_id_rs || bus.id_ex_rt == bus.if_id_rt);
  always_comb begin
    {pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we} = '1;
    {if_id_fl, id_ex_fl, ex_mem_fl, mem_wb_fl} = '0;
    mp_srv = 1'b0;
    state_d = state_q;
    case (state_q)
      RUN: begin
        if (bus.dmiss) begin
          {pc_we, if_id_we, id_ex_we, ex_mem_we} = '0;
          mem_wb_fl = 1'b1;
          state_d = DSTALL;
        end else if (bus.mispredict) begin
          {if_id_fl, id_ex_fl, ex_mem_fl} = '1;
          mp_srv = 1'b1;
        end else if (bus.imiss) begin
          pc_we = 1'b0;
          if_id_fl = 1'b1;
          state_d = ISTALL;
        end else if (load_use) begin
          {pc_we, if_id_we} = '0;
          id_ex_fl = 1'b1;
        end
      end
      DSTALL: begin
        {pc_we, if_id_we, id_ex_we, ex_mem_we} = '0;
        mem_wb_fl = 1'b1;
        state_d = bus.dcache_fill_done ? RUN : DSTALL;
      end
      ISTALL: begin
        if (bus.dmiss) begin
          {pc_we, if_id_we, id_ex_we, ex_mem_we} = '0;
          mem_wb_fl = 1'b1;
          state_d = bus.icache_fill_done ? DSTALL : ISTALL_DFRZ;
        end else begin
          if_id_fl = 1'b1;
          pc_we = bus.mispredict;
          // a redirect overrides the load-use stall while the fetch keeps waiting
          if (bus.mispredict) begin
            {id_ex_fl, ex_mem_fl} = '1;
            mp_srv = 1'b1;
          end else if (load_use) begin
            if_id_we = 1'b0;
            id_ex_fl = 1'b1;
          end
          state_d = bus.icache_fill_done ? RUN : ISTALL;
        end
      end
      default: begin
        {pc_we, if_id_we, id_ex_we, ex_mem_we} = '0;
        mem_wb_fl = 1'b1;
        state_d = bus.icache_fill_done ? DSTALL : ISTALL_DFRZ;
      end
    endcase
    icache_fill_req_d = state_d == ISTALL || state_d == ISTALL_DFRZ;
    dcache_fill_req_d = state_d == DSTALL;
    stall_cnt_d = (!pc_we && !(&stall_cnt_q)) ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;
    flush_cnt_d = (mp_srv && !(&flush_cnt_q)) ? flush_cnt_q + CNT_W'(1) : flush_cnt_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      icache_fill_req_q <= 1'b0;
      dcache_fill_req_q <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      icache_fill_req_q <= icache_fill_req_d;
      dcache_fill_req_q <= dcache_fill_req_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end
  assign bus.icache_fill_req = icache_fill_req_q;
  assign bus.dcache_fill_req = dcache_fill_req_q;
  assign bus.stall_cnt = stall_cnt_q;
  assign bus.flush_cnt = flush_cnt_q;
  assign bus.pc_write_en = pc_we & ~rst;
  assign bus.if_id_write_en = if_id_we & ~rst;
  assign bus.id_ex_write_en = id_ex_we & ~rst;
  assign bus.ex_mem_write_en = ex_mem_we & ~rst;
  assign bus.mem_wb_write_en = mem_wb_we & ~rst;
  assign bus.if_id_flush_en = if_id_fl & ~rst;
  assign bus.id_ex_flush_en = id_ex_fl & ~rst;
  assign bus.ex_mem_flush_en = ex_mem_fl & ~rst;
  assign bus.mem_wb_flush_en = mem_wb_fl & ~rst;
endmodule
